// File: rtl/controller_pe.sv
// controller_pe: sliding-window address generator for the PE array.
// Walks the input feature map as output position -> kernel row -> kernel
// column -> channel and presents one buffer address per accepted beat,
// wrapping back to the start of the frame after the last beat.
module controller_pe #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned IFM_W     = 8,
    parameter int unsigned IFM_H     = 8,
    parameter int unsigned CH        = 4,
    parameter int unsigned K         = 3,
    parameter int unsigned STRIDE    = 1,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,   // synchronous, active-high despite the name
    input  logic              en,
    input  logic              valid,
    output logic [ADDR_W-1:0] addr
);

    // Reject parameter sets the odometer cannot walk.
    if (K > IFM_W || K > IFM_H || STRIDE < 1 || CH < 1 || K < 1) begin : g_bad_params
        $error("controller_pe: illegal parameter combination");
    end

    localparam int unsigned OW = (IFM_W - K) / STRIDE + 1;
    localparam int unsigned OH = (IFM_H - K) / STRIDE + 1;

    localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned K_W  = (K  > 1) ? $clog2(K)  : 1;
    localparam int unsigned OW_W = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned OH_W = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH - 1);
    localparam logic [K_W-1:0]  K_LAST  = K_W'(K - 1);
    localparam logic [OW_W-1:0] OW_LAST = OW_W'(OW - 1);
    localparam logic [OH_W-1:0] OH_LAST = OH_W'(OH - 1);

    logic [CH_W-1:0]   ch_q, ch_d;
    logic [K_W-1:0]    kx_q, kx_d;
    logic [K_W-1:0]    ky_q, ky_d;
    logic [OW_W-1:0]   ox_q, ox_d;
    logic [OH_W-1:0]   oy_q, oy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [31:0] row_pos;
    logic [31:0] col_pos;
    logic [31:0] lin_addr;

    // Odometer advance on an accepted beat; the address is formed from the
    // next counter state so that it is valid in the same cycle as the counters.
    always_comb begin
        ch_d = ch_q;
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (en && valid) begin
            if (ch_q != CH_LAST) begin
                ch_d = ch_q + CH_W'(1);
            end else begin
                ch_d = '0;
                if (kx_q != K_LAST) begin
                    kx_d = kx_q + K_W'(1);
                end else begin
                    kx_d = '0;
                    if (ky_q != K_LAST) begin
                        ky_d = ky_q + K_W'(1);
                    end else begin
                        ky_d = '0;
                        if (ox_q != OW_LAST) begin
                            ox_d = ox_q + OW_W'(1);
                        end else begin
                            ox_d = '0;
                            // Last window of the frame wraps oy back to 0.
                            if (oy_q != OH_LAST) begin
                                oy_d = oy_q + OH_W'(1);
                            end else begin
                                oy_d = '0;
                            end
                        end
                    end
                end
            end
        end

        row_pos  = 32'(oy_d) * STRIDE + 32'(ky_d);
        col_pos  = 32'(ox_d) * STRIDE + 32'(kx_d);
        lin_addr = BASE_ADDR + (row_pos * IFM_W + col_pos) * CH + 32'(ch_d);
        addr_d   = ADDR_W'(lin_addr);
    end

    // Counter and address registers; reset restarts the frame at the base.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            ch_q   <= '0;
            kx_q   <= '0;
            ky_q   <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            addr_q <= ADDR_W'(BASE_ADDR);
        end else begin
            ch_q   <= ch_d;
            kx_q   <= kx_d;
            ky_q   <= ky_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: tb/tb_controller_pe.sv
// Testbench for controller_pe with default parameters (6x6 windows,
// 36 beats per window, 1296 beats per frame).
module tb_controller_pe;

    localparam int unsigned P_ADDR_W = 20;
    localparam int unsigned P_IFM_W  = 8;
    localparam int unsigned P_IFM_H  = 8;
    localparam int unsigned P_CH     = 4;
    localparam int unsigned P_K      = 3;
    localparam int unsigned P_STRIDE = 1;
    localparam int unsigned P_BASE   = 0;
    localparam int unsigned P_OW     = (P_IFM_W - P_K) / P_STRIDE + 1;
    localparam int unsigned P_OH     = (P_IFM_H - P_K) / P_STRIDE + 1;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                en = 1'b0;
    logic                valid = 1'b0;
    logic [P_ADDR_W-1:0] addr;

    int vec_count = 0;
    int fail_count = 0;

    // Reference odometer
    int unsigned m_ch = 0, m_kx = 0, m_ky = 0, m_ox = 0, m_oy = 0;
    logic [P_ADDR_W-1:0] exp_q[$];

    typedef struct {
        logic                rst;
        logic                e;
        logic                v;
        int                  n;
        logic [P_ADDR_W-1:0] exp;
        string               name;
    } vec_t;

    vec_t tbl[15];

    controller_pe #(
        .ADDR_W   (P_ADDR_W),
        .IFM_W    (P_IFM_W),
        .IFM_H    (P_IFM_H),
        .CH       (P_CH),
        .K        (P_K),
        .STRIDE   (P_STRIDE),
        .BASE_ADDR(P_BASE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .valid  (valid),
        .addr   (addr)
    );

    always #5 clk = ~clk;

    function automatic logic [P_ADDR_W-1:0] model_addr();
        int unsigned a;
        a = P_BASE + ((m_oy * P_STRIDE + m_ky) * P_IFM_W + (m_ox * P_STRIDE + m_kx)) * P_CH + m_ch;
        return P_ADDR_W'(a);
    endfunction

    task automatic model_step(input logic r, input logic e, input logic v);
        if (r) begin
            m_ch = 0; m_kx = 0; m_ky = 0; m_ox = 0; m_oy = 0;
        end else if (e && v) begin
            m_ch = m_ch + 1;
            if (m_ch == P_CH) begin
                m_ch = 0; m_kx = m_kx + 1;
                if (m_kx == P_K) begin
                    m_kx = 0; m_ky = m_ky + 1;
                    if (m_ky == P_K) begin
                        m_ky = 0; m_ox = m_ox + 1;
                        if (m_ox == P_OW) begin
                            m_ox = 0; m_oy = m_oy + 1;
                            if (m_oy == P_OH) m_oy = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [P_ADDR_W-1:0] act,
                         input logic [P_ADDR_W-1:0] exp);
        vec_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: addr=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, push the expected address, compare after the edge.
    task automatic cycle(input logic r, input logic e, input logic v);
        logic [P_ADDR_W-1:0] exp;
        reset_n = r;
        en      = e;
        valid   = v;
        model_step(r, e, v);
        exp_q.push_back(model_addr());
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check("scoreboard", addr, exp);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1,    20'd0,  "reset"};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 10,   20'd0,  "idle_valid0"};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 5,    20'd5,  "five_beats"};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 50,   20'd5,  "hold_valid0"};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 30,   20'd75, "end_window0"};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1,    20'd4,  "window1_start"};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 39,   20'd11, "beat75"};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 20,   20'd11, "en0_hold"};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1,    20'd0,  "reset2"};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 12,   20'd32, "row_carry"};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1283, 20'd255,"frame_last"};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1,    20'd0,  "frame_wrap"};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 7,    20'd7,  "after_wrap"};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1,    20'd0,  "reset_mid_window"};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 3,    20'd3,  "resume"};

        for (int i = 0; i < 15; i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                cycle(tbl[i].rst, tbl[i].e, tbl[i].v);
            end
            check(tbl[i].name, addr, tbl[i].exp);
            $display("row %0d %s: rst=%0b en=%0b valid=%0b cycles=%0d addr=%0d exp=%0d",
                     i, tbl[i].name, tbl[i].rst, tbl[i].e, tbl[i].v, tbl[i].n, addr, tbl[i].exp);
        end

        // en and valid toggling in opposite phase: never a beat.
        cycle(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, c[0], ~c[0]);
        end
        check("antiphase_hold", addr, 20'd0);
        cycle(1'b0, 1'b1, 1'b1);
        check("antiphase_then_beat", addr, 20'd1);
        $display("seq antiphase: addr=%0d", addr);

        // Random en/valid with occasional reset, checked by the scoreboard.
        for (int c = 0; c < 1500; c++) begin
            cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0));
        end
        $display("seq random: addr=%0d", addr);

        // Hold reset while beats are offered, then release and count from 0.
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        check("reset_held", addr, 20'd0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check("release_count", addr, 20'd2);
        $display("seq reset_release: addr=%0d", addr);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
